// File: rtl/ysyx_22050078_ifu_fetch_if.sv
// rtl/ysyx_22050078_ifu_fetch_if.sv - instruction memory request/response bus between fetch unit and imem
interface ysyx_22050078_ifu_fetch_if #(
   parameter int CPU_WIDTH  = 64,
   parameter int INST_WIDTH = 32
);
   logic                  imem_req_valid;
   logic [CPU_WIDTH-1:0]  imem_addr;
   logic                  imem_req_ready;
   logic                  imem_rsp_valid;
   logic [INST_WIDTH-1:0] imem_rsp_data;

   // fetch unit side: issues requests, consumes responses
   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   // memory side: accepts requests, produces responses
   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/ysyx_22050078_ifu_fetch.sv
// rtl/ysyx_22050078_ifu_fetch.sv - single-outstanding instruction fetch unit feeding the IF/ID register
module ysyx_22050078_ifu_fetch #(
   parameter int                   CPU_WIDTH  = 64,
   parameter int                   INST_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(64'h8000_0000)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_stall,
   input  logic                      i_redirect,
   input  logic [CPU_WIDTH-1:0]      i_redirect_pc,
   ysyx_22050078_ifu_fetch_if.master imem,
   output logic                      o_ifu_valid,
   output logic [INST_WIDTH-1:0]     o_ifu_inst,
   output logic [CPU_WIDTH-1:0]      o_ifu_pc
);

   // S_REQ : presenting a request at pc_q
   // S_WAIT: request accepted, waiting for its response
   // S_HOLD: instruction captured, offered to IF/ID until consumed or redirected
   // S_DROP: redirected while a response is still owed; swallow it when it comes
   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

   logic [1:0]            state_q,   state_d;
   logic [CPU_WIDTH-1:0]  pc_q,      pc_d;
   logic [INST_WIDTH-1:0] inst_q,    inst_d;
   logic [CPU_WIDTH-1:0]  ifu_pc_q,  ifu_pc_d;
   logic [CPU_WIDTH-1:0]  redirect_target;

   // instructions are word aligned, so the low two bits of a target are dropped
   assign redirect_target = i_redirect_pc & ~CPU_WIDTH'(3);

   // a redirect cycle never issues a request nor offers a (now wrong-path) instruction
   assign imem.imem_req_valid = (state_q == S_REQ) && !i_redirect;
   assign imem.imem_addr      = pc_q;
   assign o_ifu_valid         = (state_q == S_HOLD) && !i_redirect;
   assign o_ifu_inst          = inst_q;
   assign o_ifu_pc            = ifu_pc_q;

   // next-state and datapath: redirect outranks response, stall and handshake
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      ifu_pc_d = ifu_pc_q;
      case (state_q)
         S_REQ: begin
            if (i_redirect) begin
               pc_d = redirect_target;
            end else if (imem.imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_redirect && imem.imem_rsp_valid) begin
               pc_d    = redirect_target;
               state_d = S_REQ;
            end else if (imem.imem_rsp_valid) begin
               inst_d   = imem.imem_rsp_data;
               ifu_pc_d = pc_q;
               state_d  = S_HOLD;
            end else if (i_redirect) begin
               pc_d    = redirect_target;
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            // a redirect landing with the owed response still retires the drop
            if (i_redirect) begin
               pc_d = redirect_target;
            end
            if (imem.imem_rsp_valid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            if (i_redirect) begin
               pc_d    = redirect_target;
               state_d = S_REQ;
            end else if (!i_stall) begin
               pc_d    = pc_q + CPU_WIDTH'(4);
               state_d = S_REQ;
            end
         end
      endcase
   end

   // state registers; reset abandons any outstanding request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         inst_q   <= NOP_INST;
         ifu_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         ifu_pc_q <= ifu_pc_d;
      end
   end

endmodule
